dmem_arbiter: RTL

//  Shares the single-port, variable-latency data memory between two requesters:

---
 rtl/dmem_arbiter_if.sv | 48 ++++
 rtl/dmem_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester and data-memory signal bundle for dmem_arbiter.
// slave: the arbiter's view. master: the requester/memory side.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // Port 0: load/store unit
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              done0;

  // Port 1: debug/DMA loader
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              done1;

  // Shared completion status
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  // Data-memory pins
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_rdata, mem_ready,
    output done0, done1, err, rdata, busy,
    output mem_write, mem_address, mem_wdata
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_rdata, mem_ready,
    input  done0, done1, err, rdata, busy,
    input  mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one variable-latency data memory between the
// load/store unit (port 0) and the debug/DMA loader (port 1). One access is
// in flight at a time; address and write data are held for the whole access.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned WAIT_MIN = 2,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

  // Read-wait counter; TIMEOUT is constrained below 2**8.
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic              gnt;
  logic              last_grant;
  logic [CNT_W-1:0]  cnt;

  logic              any_req_c;
  logic              pick_c;
  logic              sel_we_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_wdata_c;
  logic              rd_accept_c;
  logic              rd_timeout_c;

  // Pick the winning port: a lone requester wins, a tie goes to the port not served last.
  always_comb begin
    any_req_c = bus.req0 | bus.req1;
    pick_c    = 1'b0;
    if (bus.req0 && bus.req1) begin
      pick_c = ~last_grant;
    end else if (bus.req1) begin
      pick_c = 1'b1;
    end
    sel_we_c    = pick_c ? bus.we1    : bus.we0;
    sel_addr_c  = pick_c ? bus.addr1  : bus.addr0;
    sel_wdata_c = pick_c ? bus.wdata1 : bus.wdata0;
  end

  // Read completion: mem_ready is trusted only once the memory has had time to drop it.
  always_comb begin
    rd_accept_c  = (cnt >= CNT_W'(WAIT_MIN)) && bus.mem_ready;
    rd_timeout_c = (cnt == CNT_W'(TIMEOUT));
  end

  // Access sequencer with registered memory pins and completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      gnt             <= 1'b0;
      last_grant      <= 1'b1;
      cnt             <= '0;
      bus.done0       <= 1'b0;
      bus.done1       <= 1'b0;
      bus.err         <= 1'b0;
      bus.rdata       <= '0;
      bus.busy        <= 1'b0;
      bus.mem_write   <= 1'b0;
      bus.mem_address <= '0;
      bus.mem_wdata   <= '0;
    end else begin
      bus.done0     <= 1'b0;
      bus.done1     <= 1'b0;
      bus.mem_write <= 1'b0;

      case (state)
        IDLE: begin
          if (any_req_c) begin
            gnt             <= pick_c;
            last_grant      <= pick_c;
            cnt             <= '0;
            bus.mem_address <= sel_addr_c;
            bus.mem_wdata   <= sel_wdata_c;
            bus.busy        <= 1'b1;
            if (sel_we_c) begin
              state         <= WRITE;
              bus.mem_write <= 1'b1;
            end else begin
              state <= READ;
            end
          end
        end

        // mem_write is high for this single cycle; the memory stores on its closing edge.
        WRITE: begin
          state     <= DONE;
          bus.done0 <= ~gnt;
          bus.done1 <= gnt;
        end

        READ: begin
          if (cnt != CNT_W'(TIMEOUT)) begin
            cnt <= cnt + CNT_W'(1);
          end
          if (rd_accept_c) begin
            state     <= DONE;
            bus.rdata <= bus.mem_rdata;
            bus.err   <= 1'b0;
            bus.done0 <= ~gnt;
            bus.done1 <= gnt;
          end else if (rd_timeout_c) begin
            state     <= DONE;
            bus.rdata <= '0;
            bus.err   <= 1'b1;
            bus.done0 <= ~gnt;
            bus.done1 <= gnt;
          end
        end

        // Completion pulse is visible this cycle; requests seen here wait for IDLE.
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
